bus_cycle_ctrl: RTL and testbench



---
 rtl/pixy_bus_pkg.sv | 73 +++++++
 rtl/bus_cycle_ctrl_step_sync.sv | 35 +++
 rtl/bus_cycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pixy_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixy_bus_pkg
//  Description : Shared types, constants and the address-decode function for
//                the Pixy-68000 bus-cycle controller.
//  Revision    : 1.0  initial release
// ============================================================================
package pixy_bus_pkg;

   // Width of the per-region wait-state counter (wait values 0..15)
   localparam int WAIT_W = 4;

   // Default memory map of the Pixy-68000 board
   localparam int          DEF_ADDR_W     = 24;
   localparam int          DEF_BANK_BITS  = 19;
   localparam int          DEF_PROM_BANKS = 2;
   localparam int          DEF_SRAM_BANKS = 2;
   localparam logic [31:0] DEF_SRAM_BASE  = 32'h0010_0000;
   localparam int          DEF_PROM_WAIT  = 2;
   localparam int          DEF_SRAM_WAIT  = 0;

   // Bus-cycle FSM state encoding
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_DECODE = 3'd1;
   localparam state_t ST_WAIT   = 3'd2;
   localparam state_t ST_HOLD   = 3'd3;
   localparam state_t ST_ACK    = 3'd4;
   localparam state_t ST_ERR    = 3'd5;

   // Memory region selected by an address
   typedef enum logic [1:0] {
      REG_NONE = 2'd0,
      REG_PROM = 2'd1,
      REG_SRAM = 2'd2
   } region_e;

   // Result of an address decode: region plus bank index inside it
   typedef struct packed {
      region_e    region;
      logic [7:0] bank;
   } decode_t;

   // Map a byte address onto {region, bank}. PROM starts at zero; SRAM starts
   // at an aligned base, so the bank index equals the address bits just above
   // the bank offset. A0 never affects the result because banks are far larger
   // than one word.
   function automatic decode_t pixy_decode(
      input logic [31:0] addr,
      input int          bank_bits,
      input int          prom_banks,
      input int          sram_banks,
      input logic [31:0] sram_base
   );
      decode_t     d;
      logic [31:0] prom_top;
      logic [31:0] sram_top;
      d.region = REG_NONE;
      d.bank   = 8'd0;
      prom_top = 32'(prom_banks) << bank_bits;
      sram_top = sram_base + (32'(sram_banks) << bank_bits);
      if (addr < prom_top) begin
         d.region = REG_PROM;
         d.bank   = 8'(addr >> bank_bits);
      end else if ((addr >= sram_base) && (addr < sram_top)) begin
         d.region = REG_SRAM;
         d.bank   = 8'((addr - sram_base) >> bank_bits);
      end
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bus_cycle_ctrl_step_sync.sv
`default_nettype none
// ============================================================================
//  Module      : step_sync
//  Description : Two-flop synchroniser for the asynchronous STEP button plus
//                a one-clock rising-edge pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module step_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_step,
   output logic o_pulse
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Bring STEP into the clock domain and keep one cycle of history
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_step;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_pulse = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_cycle_ctrl
//  Description : 68000 bus-cycle controller: chip-select decode for PROM and
//                SRAM banks, per-region wait states, bus error on unmapped or
//                illegal cycles, and single-step hold of every bus cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_cycle_ctrl
   import pixy_bus_pkg::*;
#(
   parameter int          ADDR_W     = DEF_ADDR_W,
   parameter int          BANK_BITS  = DEF_BANK_BITS,
   parameter int          PROM_BANKS = DEF_PROM_BANKS,
   parameter int          SRAM_BANKS = DEF_SRAM_BANKS,
   parameter logic [31:0] SRAM_BASE  = DEF_SRAM_BASE,
   parameter int          PROM_WAIT  = DEF_PROM_WAIT,
   parameter int          SRAM_WAIT  = DEF_SRAM_WAIT
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [ADDR_W-1:0]     A,
   input  logic                  AS_N,
   input  logic                  RW,
   input  logic                  STEPEN,
   input  logic                  STEP,
   output logic [PROM_BANKS-1:0] PROMCS_N,
   output logic [SRAM_BANKS-1:0] SRAMCS_N,
   output logic                  OE_N,
   output logic                  WE_N,
   output logic                  DTACK_N,
   output logic                  BERR_N,
   output logic                  RUN
);

   localparam logic [WAIT_W-1:0] c_prom_wait = PROM_WAIT[WAIT_W-1:0];
   localparam logic [WAIT_W-1:0] c_sram_wait = SRAM_WAIT[WAIT_W-1:0];

   state_t              r_state;
   state_t              w_next;
   logic [WAIT_W-1:0]   r_cnt;
   logic [WAIT_W-1:0]   w_cnt_next;
   region_e             r_region;
   logic [7:0]          r_bank;
   logic                r_rw;
   logic                r_stepen;

   decode_t             w_dec;
   logic [WAIT_W-1:0]   w_wait_dec;
   region_e             w_region_n;
   logic [7:0]          w_bank_n;
   logic                w_rw_n;
   logic                w_strobe;
   logic                w_step_pulse;
   logic [PROM_BANKS-1:0] w_prom_sel;
   logic [SRAM_BANKS-1:0] w_sram_sel;

   step_sync u_step_sync (
      .clk     (CLK),
      .rst     (RESET),
      .i_step  (STEP),
      .o_pulse (w_step_pulse)
   );

   assign w_dec      = pixy_decode(32'(A), BANK_BITS, PROM_BANKS, SRAM_BANKS, SRAM_BASE);
   assign w_wait_dec = (w_dec.region == REG_PROM) ? c_prom_wait : c_sram_wait;

   // Cycle attributes as they will be after this edge: DECODE captures them
   // from the bus, every later state keeps the latched copy.
   assign w_region_n = (r_state == ST_DECODE) ? w_dec.region : r_region;
   assign w_bank_n   = (r_state == ST_DECODE) ? w_dec.bank   : r_bank;
   assign w_rw_n     = (r_state == ST_DECODE) ? RW           : r_rw;

   // Strobes are live in every state that belongs to an accepted memory cycle
   assign w_strobe = (w_next == ST_WAIT) || (w_next == ST_HOLD) || (w_next == ST_ACK);

   // One-hot bank selects; only the latched region's bank can ever match
   for (genvar i = 0; i < PROM_BANKS; i++) begin : g_prom_cs
      assign w_prom_sel[i] = w_strobe && (w_region_n == REG_PROM) && (w_bank_n == 8'(i));
   end

   for (genvar j = 0; j < SRAM_BANKS; j++) begin : g_sram_cs
      assign w_sram_sel[j] = w_strobe && (w_region_n == REG_SRAM) && (w_bank_n == 8'(j));
   end

   // Next-state and wait-counter logic; AS_N high aborts any unfinished cycle
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (!AS_N) begin
               w_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (AS_N) begin
               w_next = ST_IDLE;
            end else if ((w_dec.region == REG_NONE) ||
                         ((w_dec.region == REG_PROM) && !RW)) begin
               w_next = ST_ERR;
            end else begin
               w_cnt_next = w_wait_dec;
               if (w_wait_dec != '0) begin
                  w_next = ST_WAIT;
               end else if (STEPEN) begin
                  w_next = ST_HOLD;
               end else begin
                  w_next = ST_ACK;
               end
            end
         end
         ST_WAIT: begin
            if (AS_N) begin
               w_next = ST_IDLE;
            end else if (r_cnt <= WAIT_W'(1)) begin
               w_cnt_next = '0;
               w_next     = r_stepen ? ST_HOLD : ST_ACK;
            end else begin
               w_cnt_next = r_cnt - WAIT_W'(1);
            end
         end
         ST_HOLD: begin
            if (AS_N) begin
               w_next = ST_IDLE;
            end else if (w_step_pulse || !STEPEN) begin
               w_next = ST_ACK;
            end
         end
         ST_ACK, ST_ERR: begin
            if (AS_N) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // State, cycle attributes and registered bus outputs
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_region <= REG_NONE;
         r_bank   <= 8'd0;
         r_rw     <= 1'b1;
         r_stepen <= 1'b0;
         PROMCS_N <= '1;
         SRAMCS_N <= '1;
         OE_N     <= 1'b1;
         WE_N     <= 1'b1;
         DTACK_N  <= 1'b1;
         BERR_N   <= 1'b1;
         RUN      <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_cnt    <= w_cnt_next;
         r_region <= w_region_n;
         r_bank   <= w_bank_n;
         r_rw     <= w_rw_n;
         if (r_state == ST_DECODE) begin
            r_stepen <= STEPEN;
         end
         PROMCS_N <= ~w_prom_sel;
         SRAMCS_N <= ~w_sram_sel;
         OE_N     <= ~(w_strobe && w_rw_n);
         WE_N     <= ~(w_strobe && !w_rw_n && (w_region_n == REG_SRAM));
         DTACK_N  <= ~(w_next == ST_ACK);
         BERR_N   <= ~(w_next == ST_ERR);
         RUN      <= (w_next != ST_HOLD);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_cycle_ctrl
//  Description : Directed, table-driven bench for bus_cycle_ctrl with the
//                default Pixy-68000 memory map.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_cycle_ctrl;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [23:0] A = 24'h0;
   logic        AS_N = 1'b1;
   logic        RW = 1'b1;
   logic        STEPEN = 1'b0;
   logic        STEP = 1'b0;
   logic [1:0]  PROMCS_N;
   logic [1:0]  SRAMCS_N;
   logic        OE_N;
   logic        WE_N;
   logic        DTACK_N;
   logic        BERR_N;
   logic        RUN;

   int total = 0;
   int bad   = 0;

   // Output vector layout: {PROMCS_N, SRAMCS_N, OE_N, WE_N, DTACK_N, BERR_N, RUN}
   localparam logic [8:0] c_idle  = 9'b11_11_1111_1;
   localparam logic [8:0] c_reset = 9'b11_11_1111_0;

   typedef struct {
      string      name;
      logic [23:0] addr;
      logic       rw;
      logic [1:0] prom;
      logic [1:0] sram;
      logic       oe;
      logic       we;
      logic       berr;
      int         ack;     // edge at which DTACK_N goes low, 0 = never
   } vec_t;

   vec_t vecs[9];

   bus_cycle_ctrl dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .A        (A),
      .AS_N     (AS_N),
      .RW       (RW),
      .STEPEN   (STEPEN),
      .STEP     (STEP),
      .PROMCS_N (PROMCS_N),
      .SRAMCS_N (SRAMCS_N),
      .OE_N     (OE_N),
      .WE_N     (WE_N),
      .DTACK_N  (DTACK_N),
      .BERR_N   (BERR_N),
      .RUN      (RUN)
   );

   always #5 CLK = ~CLK;

   function automatic logic [8:0] outs();
      return {PROMCS_N, SRAMCS_N, OE_N, WE_N, DTACK_N, BERR_N, RUN};
   endfunction

   task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One complete bus cycle with STEPEN=0, checked edge by edge
   task automatic run_vec(input vec_t v);
      logic [8:0] exp;
      A    = v.addr;
      RW   = v.rw;
      AS_N = 1'b0;
      tick();
      check({v.name, " e0"}, outs(), c_idle);
      for (int k = 1; k <= 4; k++) begin
         tick();
         exp = {v.prom, v.sram, v.oe, v.we,
                ((v.ack != 0) && (k >= v.ack)) ? 1'b0 : 1'b1, v.berr, 1'b1};
         check($sformatf("%s e%0d", v.name, k), outs(), exp);
      end
      AS_N = 1'b1;
      tick();
      check({v.name, " release"}, outs(), c_idle);
      tick();
   endtask

   initial begin
      int  found;
      vecs[0] = '{"prom_rd_b0",  24'h000100, 1'b1, 2'b10, 2'b11, 1'b0, 1'b1, 1'b1, 3};
      vecs[1] = '{"sram_wr_b1",  24'h180000, 1'b0, 2'b11, 2'b01, 1'b1, 1'b0, 1'b1, 1};
      vecs[2] = '{"prom_wr_err", 24'h000010, 1'b0, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 0};
      vecs[3] = '{"unmapped_rd", 24'h300000, 1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 0};
      vecs[4] = '{"prom_rd_b1",  24'h080000, 1'b1, 2'b01, 2'b11, 1'b0, 1'b1, 1'b1, 3};
      vecs[5] = '{"sram_rd_b0",  24'h100002, 1'b1, 2'b11, 2'b10, 1'b0, 1'b1, 1'b1, 1};
      vecs[6] = '{"prom_top_rd", 24'h0FFFFF, 1'b1, 2'b01, 2'b11, 1'b0, 1'b1, 1'b1, 3};
      vecs[7] = '{"sram_end_rd", 24'h200000, 1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 0};
      vecs[8] = '{"sram_top_wr", 24'h1FFFFE, 1'b0, 2'b11, 2'b01, 1'b1, 1'b0, 1'b1, 1};

      // reset values, then RUN rises on the first edge after release
      tick();
      check("reset", outs(), c_reset);
      RESET = 1'b0;
      tick();
      check("after_reset", outs(), c_idle);

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i]);
      end

      // single-step: SRAM read held until STEP
      STEPEN = 1'b1;
      A = 24'h100000;
      RW = 1'b1;
      AS_N = 1'b0;
      tick();
      tick();
      check("hold_e1", outs(), 9'b11_10_01_1_1_0);
      for (int k = 0; k < 20; k++) begin
         tick();
         check($sformatf("hold_c%0d", k), outs(), 9'b11_10_01_1_1_0);
      end
      STEP  = 1'b1;
      found = 0;
      for (int k = 1; k <= 6 && found == 0; k++) begin
         tick();
         if (!DTACK_N) found = k;
      end
      STEP = 1'b0;
      total++;
      if ((found == 0) || (found > 4)) begin
         bad++;
         $display("FAIL step_latency: got %0d edges want 1..4", found);
      end
      check("step_ack", outs(), 9'b11_10_01_0_1_1);
      AS_N = 1'b1;
      tick();
      check("step_release", outs(), c_idle);

      // STEP during IDLE must not release the next held cycle
      STEP = 1'b1;
      repeat (3) tick();
      STEP = 1'b0;
      repeat (4) tick();
      AS_N = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("idle_step_hold%0d", k), outs(), 9'b11_10_01_1_1_0);
      end
      // dropping STEPEN in HOLD releases the cycle on the next edge
      STEPEN = 1'b0;
      tick();
      check("stepen_drop_ack", outs(), 9'b11_10_01_0_1_1);
      AS_N = 1'b1;
      tick();
      check("stepen_drop_release", outs(), c_idle);
      tick();

      // abort during PROM wait states
      A = 24'h000100;
      RW = 1'b1;
      AS_N = 1'b0;
      tick();
      tick();
      tick();
      check("abort_wait_e2", outs(), 9'b10_11_01_1_1_1);
      AS_N = 1'b1;
      tick();
      check("abort_idle", outs(), c_idle);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("abort_no_dtack%0d", k), outs(), c_idle);
      end

      // reset while held
      STEPEN = 1'b1;
      A = 24'h100000;
      AS_N = 1'b0;
      repeat (4) tick();
      check("rst_hold", outs(), 9'b11_10_01_1_1_0);
      RESET = 1'b1;
      AS_N  = 1'b1;
      STEPEN = 1'b0;
      tick();
      check("rst_in_hold", outs(), c_reset);
      RESET = 1'b0;
      tick();
      check("rst_release", outs(), c_idle);
      run_vec(vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard ceiling so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
